// File: rtl/sw_pin_pkg.sv
// Shared types and helpers for the single-wire pin controller.
// Optional build macro used by this slice: SW_PIN_READBACK_CHECK_EN.
package sw_pin_pkg;

  // Phase sequence of the shared pin.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX,
    ST_TURN,
    ST_RX,
    ST_RESP
  } state_e;

  // Default geometry of the controller.
  localparam int DATA_W_DEF   = 8;
  localparam int LEN_W_DEF    = 4;
  localparam int BIT_CYC_DEF  = 4;
  localparam int TURN_CYC_DEF = 2;

  // Clock index within a bit period at which the pin is sampled.
  localparam int SAMPLE_IDX = BIT_CYC_DEF / 2;

  // Sample index for an arbitrary bit period length.
  function automatic int sample_idx(input int bit_cyc);
    return bit_cyc / 2;
  endfunction

  // Requested lengths beyond the shift register width are clamped.
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/sw_pin_bit_timer.sv
// Down-counter timing one bit period or one turnaround window.
// A load sets the window length; bit_end marks its last clock and
// sample_pt marks the mid-bit sampling clock.
module sw_pin_bit_timer #(
  parameter int CW         = 3,
  parameter int SAMPLE_CNT = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic          bit_end_o,
  output logic          sample_pt_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Reload on request, otherwise count down and park at 1.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q > CW'(1)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign bit_end_o   = (cnt_q == CW'(1));
  assign sample_pt_o = (cnt_q == CW'(SAMPLE_CNT));

endmodule

// File: rtl/sw_pin_ctrl.sv
// Half-duplex single-wire pin controller: TX, turnaround, RX, response.
// Optional macro SW_PIN_READBACK_CHECK_EN adds err_contention_o, a sticky
// flag set when the pin reads back differently from what TX drives.
module sw_pin_ctrl
  import sw_pin_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LEN_W    = LEN_W_DEF,
  parameter int BIT_CYC  = BIT_CYC_DEF,
  parameter int TURN_CYC = TURN_CYC_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [DATA_W-1:0] cmd_tx_data_i,
  input  logic [LEN_W-1:0]  cmd_tx_len_i,
  input  logic [LEN_W-1:0]  cmd_rx_len_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rx_data_o,
  output logic              busy_o,
  output logic              io_oe_o,
  output logic              io_out_o,
  input  logic              io_in_i
`ifdef SW_PIN_READBACK_CHECK_EN
  ,
  output logic              err_contention_o
`endif
);

  localparam int MAXC = (BIT_CYC > TURN_CYC) ? BIT_CYC : TURN_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  // Counter value at the sample clock (the counter starts at BIT_CYC).
  localparam int SAMPLE_CNT = BIT_CYC - sample_idx(BIT_CYC);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [LEN_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [LEN_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic              cmd_ready_q, rsp_valid_q, io_oe_q, io_out_q;
  logic              err_q, err_d;
  logic              tmr_load, bit_end, sample_pt;
  logic [CW-1:0]     tmr_val;
  logic [LEN_W-1:0]  tx_len_c, rx_len_c;

  assign tx_len_c = LEN_W'(clamp_len(32'(cmd_tx_len_i), DATA_W));
  assign rx_len_c = LEN_W'(clamp_len(32'(cmd_rx_len_i), DATA_W));

  sw_pin_bit_timer #(
    .CW         (CW),
    .SAMPLE_CNT (SAMPLE_CNT)
  ) u_timer (
    .clock       (clock),
    .reset       (reset),
    .load_i      (tmr_load),
    .load_val_i  (tmr_val),
    .bit_end_o   (bit_end),
    .sample_pt_o (sample_pt)
  );

  // Phase sequencing, shift registers and timer reloads.
  always_comb begin
    state_d    = state_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    rx_cnt_d   = rx_cnt_q;
    err_d      = err_q;
    tmr_load   = 1'b0;
    tmr_val    = CW'(BIT_CYC);
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          // Left-align the low tx_len bits so the MSB is sent first.
          tx_shift_d = cmd_tx_data_i << (DATA_W - int'(tx_len_c));
          rx_shift_d = '0;
          tx_cnt_d   = tx_len_c;
          rx_cnt_d   = rx_len_c;
          err_d      = 1'b0;
          tmr_load   = 1'b1;
          if (tx_len_c != '0) begin
            state_d = ST_TX;
          end else if (rx_len_c != '0) begin
            state_d = ST_TURN;
            tmr_val = CW'(TURN_CYC);
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_TX: begin
`ifdef SW_PIN_READBACK_CHECK_EN
        if (sample_pt && (io_in_i != io_out_q)) err_d = 1'b1;
`endif
        if (bit_end) begin
          tx_shift_d = tx_shift_q << 1;
          tx_cnt_d   = tx_cnt_q - LEN_W'(1);
          tmr_load   = 1'b1;
          if (tx_cnt_q == LEN_W'(1)) begin
            if (rx_cnt_q != '0) begin
              state_d = ST_TURN;
              tmr_val = CW'(TURN_CYC);
            end else begin
              state_d = ST_RESP;
            end
          end
        end
      end
      ST_TURN: begin
        if (bit_end) begin
          state_d  = ST_RX;
          tmr_load = 1'b1;
        end
      end
      ST_RX: begin
        if (sample_pt) rx_shift_d = {rx_shift_q[DATA_W-2:0], io_in_i};
        if (bit_end) begin
          rx_cnt_d = rx_cnt_q - LEN_W'(1);
          tmr_load = 1'b1;
          if (rx_cnt_q == LEN_W'(1)) state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; pin outputs are registered from next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      tx_cnt_q    <= '0;
      rx_cnt_q    <= '0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      io_oe_q     <= 1'b0;
      io_out_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      err_q       <= err_d;
      cmd_ready_q <= (state_d == ST_IDLE);
      rsp_valid_q <= (state_d == ST_RESP);
      io_oe_q     <= (state_d == ST_TX);
      io_out_q    <= (state_d == ST_TX) ? tx_shift_d[DATA_W-1] : 1'b0;
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rx_data_o = rx_shift_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign io_oe_o       = io_oe_q;
  assign io_out_o      = io_out_q;
`ifdef SW_PIN_READBACK_CHECK_EN
  assign err_contention_o = err_q;
`else
  // Without the readback check, err_q is never set.
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: doc/sw_pin_ctrl.md
Name: sw_pin_ctrl

Overview:
Half-duplex single-wire pin controller. Sequences one shared bidirectional pin through transmit, turnaround and receive phases for a command/response requester. The bit-serial engine owns pin direction, so the enable and value are never driven by ad-hoc debug registers. The top level resolves the pin as: io driven with io_out when io_oe=1, else high-Z; pull-up on the pin.

Parameters:
DATA_W, 8, width of the tx/rx shift registers
LEN_W, 4, width of the length fields; values above DATA_W clamp to DATA_W
BIT_CYC, 4, clocks per bit period; legal values are 2 or more
TURN_CYC, 2, undriven clocks between the TX and RX phases; legal values are 1 or more

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE
cmd_tx_data  in  DATA_W  data to send; the low tx_len bits are sent MSB-first
cmd_tx_len  in  LEN_W  number of bits to transmit (0 is allowed)
cmd_rx_len  in  LEN_W  number of bits to receive (0 is allowed)
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_rx_data  out  DATA_W  received bits, right-aligned, first bit received is most significant
busy  out  1  asserted whenever the state is not IDLE
io_oe  out  1  pin drive enable
io_out  out  1  pin drive value
io_in  in  1  pin readback

Behaviour:
- Clock and reset: reset is asynchronous, active-high; clock is clock.
- Reset values: cmd_ready=0 while reset is asserted, then 1 on the first clock edge after release. rsp_valid=0, rsp_rx_data=0, busy=0, io_oe=0, io_out=0.
- Reset mid-operation: io_oe drops immediately (asynchronous) and the state returns to IDLE. The in-flight command is lost and no response is produced.
- States: IDLE, TX, TURN, RX, RESP.
- IDLE:
  - Accept a command on cmd_valid && cmd_ready. Latch the data and the clamped lengths.
  - Next state: TX if tx_len>0; else TURN if rx_len>0; else RESP.
- TX:
  - io_oe=1. io_out = current bit, held for exactly BIT_CYC clocks per bit.
  - Bit counter decrements after each bit period. After the last bit: TURN if rx_len>0, else RESP.
  - io_oe and io_out must be registered outputs (no glitches).
- TURN: io_oe=0 for exactly TURN_CYC clocks, then RX.
- RX:
  - io_oe=0. Sample io_in once per bit, at clock index BIT_CYC/2 within the bit period.
  - Shift left, inserting the new bit at bit 0. After rx_len bits, go to RESP.
- RESP:
  - rsp_valid=1. rsp_rx_data is stable and equals 0 when rx_len=0.
  - On rsp_valid && rsp_ready, go to IDLE; cmd_ready is high on the next cycle.
- Latency: a command accepted at cycle t raises io_oe at t+1 (if tx_len>0). rsp_valid rises at t+1+L, where L = tx_len*BIT_CYC + (rx_len>0 ? TURN_CYC + rx_len*BIT_CYC : 0).
- Both lengths zero: rsp_valid rises at t+1.
- A new cmd_valid is ignored while busy; no queuing.
- Contention is impossible by construction: io_oe is never 1 in TURN, RX or RESP.

Optional Feature:
SW_PIN_READBACK_CHECK_EN
- Defined:
  - Adds output err_contention (1 bit, reset 0).
  - In TX, at each mid-bit sample point, compare io_in with io_out. On mismatch, set a sticky err flag.
  - err_contention is reported with the response and cleared when the next command is accepted.
- Undefined: no port and no logic; io_in is ignored during TX.

Decomposition:
- Package sw_pin_pkg holds:
  - the state enum (IDLE, TX, TURN, RX, RESP);
  - the localparam for the sample index BIT_CYC/2;
  - a clamp-length function.
- One sub-module, sw_pin_bit_timer: a BIT_CYC/TURN_CYC down-counter with load and tick outputs (bit_end, sample_pt). It is reused by the TX, TURN and RX phases.

Test Plan:
1. Reset held for 2 cycles, then released -> all outputs 0 during reset; cmd_ready=1 at the first clock after release; io_oe never asserts.
2. tx_data=8'hA5, tx_len=8, rx_len=0 -> io_out sequence 1,0,1,0,0,1,0,1, each bit held 4 clocks; io_oe high for exactly 32 clocks; rsp_valid at t+33; rsp_rx_data=8'h00.
3. tx_data=8'h03, tx_len=2, rx_len=4; the bench drives 1,0,1,1 during RX -> io_out 1,1; io_oe low for exactly 2 clocks of turnaround; rsp_rx_data=8'h0B at t+1+8+2+16.
4. Both lengths 0, then rsp_ready held low for 10 cycles -> rsp_valid at t+1 and held; cmd_ready=0 and rsp_rx_data stable for all 10 cycles; IDLE one cycle after rsp_ready.
5. Assert reset during the 3rd TX bit of 8'hFF -> io_oe=0 in the same timestep; no rsp_valid afterwards; the next command completes normally.
6. (SW_PIN_READBACK_CHECK_EN) The bench forces the pin to 0 while sending 8'hFF -> err_contention=1 alongside rsp_valid; it clears when the next command is accepted.
